hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage RISC-V pipeline (F, D, E, M, W).
- Drives the stall (EN) and flush inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Generates forwarding selects for the E-stage ALU operands.
- Sequences multi-cycle data-memory waits with a timeout, and keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 16, maximum number of consecutive memory-wait cycles before abort; legal range 1..255.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- Rs1D  in  5  rs1 of the instruction in D
- Rs2D  in  5  rs2 of the instruction in D
- Rs1E  in  5  rs1 of the instruction in E
- Rs2E  in  5  rs2 of the instruction in E
- RdE  in  5  rd of the instruction in E
- RdM  in  5  rd of the instruction in M
- RdW  in  5  rd of the instruction in W
- RegWriteM  in  1  instruction in M writes rd
- RegWriteW  in  1  instruction in W writes rd
- LoadE  in  1  instruction in E is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- mem_reqM  in  1  instruction in M accesses data memory
- mem_readyM  in  1  data memory completes the access this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register (its EN; 1 = hold)
- StallE  out  1  hold D/E register
- StallM  out  1  hold E/M register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- FlushW  out  1  clear M/W register (bubble)
- ForwardAE  out  2  operand A select: 00 register file, 01 W result, 10 M ALU result
- ForwardBE  out  2  operand B select, same encoding
- mem_err  out  1  one-cycle pulse on memory timeout
- stall_cycles  out  CNT_W  count of cycles with StallF=1

Behaviour:
- FSM states: RUN, MEM_WAIT. State register, timeout counter (8 bit), mem_err and stall_cycles are registered, update on posedge clk.
- All other outputs are combinational from state and inputs.
- Reset: state=RUN, wait counter=0, mem_err=0, stall_cycles=0.
- During reset, all stall outputs are 0, FlushD=FlushE=FlushW=1, and ForwardAE=ForwardBE=00.

Forwarding (all states):
- ForwardAE=10 if Rs1E!=0, Rs1E==RdM and RegWriteM.
- Otherwise ForwardAE=01 if Rs1E!=0, Rs1E==RdW and RegWriteW.
- Otherwise ForwardAE=00.
- M has priority over W. ForwardBE follows the same rules using Rs2E.

Memory wait (mw):
- mw = (state==RUN and mem_reqM and !mem_readyM) or state==MEM_WAIT.
- When mw=1 and mem_readyM=0: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
- Branch and load-use evaluation is suppressed while mw holds; E is frozen, so PCSrcE is re-evaluated after release.
- RUN -> MEM_WAIT when mem_reqM and !mem_readyM; the wait counter is set to 1.
- MEM_WAIT with mem_readyM=1: that cycle is a normal RUN cycle (no stall from memory; branch and load-use logic apply). Next state=RUN.
- MEM_WAIT with mem_readyM=0: counter increments. When the counter reaches TIMEOUT, the next state is RUN and mem_err pulses for one cycle (next cycle).
- On the timeout cycle, stalls are released and FlushW=1, so the failed access retires as a bubble.

Branch (not mw):
- PCSrcE=1 -> FlushD=1, FlushE=1, all stalls 0.

Load-use (not mw, PCSrcE=0):
- lwStall = LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- When lwStall: StallF=StallD=1, FlushE=1, one cycle per occurrence.

Simultaneous events:
- Priority is mw > branch > load-use.
- Branch and load-use in the same cycle: only the branch flush is applied; the dependent instruction is discarded anyway.

Counter and reset:
- stall_cycles increments on every cycle with StallF=1 and saturates at all-ones.
- Reset asserted mid-wait returns to RUN immediately on the next edge and discards the wait counter.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 with matching rd -> 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> one cycle with StallF=StallD=FlushE=1. Next cycle with LoadE=0 -> all 0. stall_cycles +1.
- Branch plus load-use together: PCSrcE=1, LoadE=1, RdE=Rs1D=3 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: mem_reqM=1, mem_readyM low for 3 cycles then high -> StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, then release. stall_cycles +3. PCSrcE=1 during the wait produces no flush.
- Timeout with TIMEOUT=4: mem_readyM held 0 -> stalls for 4 cycles, release with FlushW=1, mem_err=1 for exactly one cycle, state RUN.
- Reset mid-wait: assert reset during the 2nd wait cycle -> next cycle state RUN, stall_cycles=0, mem_err=0, FlushD=FlushE=FlushW=1 while reset is high.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait control for the 5-stage pipeline.
// Also keeps a saturating count of PC-stall cycles.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             mem_reqM,
    input  logic             mem_readyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] cnt;
    logic       mw;
    logic       tmo;
    logic       lw_stall;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 5'd0 && rs == RdM && RegWriteM)
            return 2'b10;
        else if (rs != 5'd0 && rs == RdW && RegWriteW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mw = (state == RUN && mem_reqM && !mem_readyM)
              || state == MEM_WAIT;
    assign tmo = state == MEM_WAIT && cnt == TO;
    assign lw_stall = LoadE && RdE != 5'd0
                   && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = fwd(Rs1E);
        ForwardBE = fwd(Rs2E);
        if (reset) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end else if (mw && !mem_readyM) begin
            // On timeout the stuck access leaves M as a bubble.
            FlushW = 1'b1;
            if (!tmo) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 8'd0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            mem_err <= 1'b0;
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles
                              + {{(CNT_W-1){1'b0}}, 1'b1};
            case (state)
                RUN: begin
                    if (mem_reqM && !mem_readyM) begin
                        state <= MEM_WAIT;
                        cnt   <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_readyM) begin
                        state <= RUN;
                        cnt   <= 8'd0;
                    end else if (cnt == TO) begin
                        state   <= RUN;
                        cnt     <= 8'd0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4.
// Expected values are hand-derived per vector.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, PCSrcE;
    logic        mem_reqM, mem_readyM;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_err;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE),
        .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
        .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0;
        LoadE = 0; PCSrcE = 0;
        mem_reqM = 0; mem_readyM = 0;
    endtask

    task automatic chk_wait(input string tag);
        check({tag, "_sf"}, 32'(StallF), 1);
        check({tag, "_sd"}, 32'(StallD), 1);
        check({tag, "_se"}, 32'(StallE), 1);
        check({tag, "_sm"}, 32'(StallM), 1);
        check({tag, "_fw"}, 32'(FlushW), 1);
        check({tag, "_fd"}, 32'(FlushD), 0);
        check({tag, "_fe"}, 32'(FlushE), 0);
    endtask

    initial begin
        clr();
        reset = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        tick();
        check("rst_sf", 32'(StallF), 0);
        check("rst_fd", 32'(FlushD), 1);
        check("rst_fe", 32'(FlushE), 1);
        check("rst_fw", 32'(FlushW), 1);
        check("rst_fa", 32'(ForwardAE), 0);
        check("rst_cnt", 32'(stall_cycles), 0);
        check("rst_err", 32'(mem_err), 0);
        reset = 0;
        tick();

        clr();
        Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5;
        RegWriteM = 1; RegWriteW = 1;
        #1;
        check("fa_m", 32'(ForwardAE), 2);
        check("fb_m", 32'(ForwardBE), 2);
        check("idle_fd", 32'(FlushD), 0);
        RegWriteM = 0;
        #1;
        check("fa_w", 32'(ForwardAE), 1);
        Rs1E = 0;
        #1;
        check("fa_x0", 32'(ForwardAE), 0);
        check("fb_w", 32'(ForwardBE), 1);

        clr();
        LoadE = 1; RdE = 7; Rs2D = 7;
        #1;
        check("lu_sf", 32'(StallF), 1);
        check("lu_sd", 32'(StallD), 1);
        check("lu_fe", 32'(FlushE), 1);
        check("lu_fd", 32'(FlushD), 0);
        check("lu_se", 32'(StallE), 0);
        tick();
        LoadE = 0;
        #1;
        check("lu2_sf", 32'(StallF), 0);
        check("lu2_fe", 32'(FlushE), 0);
        check("lu_cnt", 32'(stall_cycles), 1);

        clr();
        PCSrcE = 1; LoadE = 1; RdE = 3; Rs1D = 3;
        #1;
        check("br_fd", 32'(FlushD), 1);
        check("br_fe", 32'(FlushE), 1);
        check("br_sf", 32'(StallF), 0);
        check("br_sd", 32'(StallD), 0);
        tick();
        check("br_cnt", 32'(stall_cycles), 1);

        clr();
        mem_reqM = 1; mem_readyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_wait($sformatf("mw%0d", i));
            tick();
        end
        mem_readyM = 1; PCSrcE = 0;
        #1;
        check("mwr_sf", 32'(StallF), 0);
        check("mwr_sm", 32'(StallM), 0);
        check("mwr_fw", 32'(FlushW), 0);
        check("mw_cnt", 32'(stall_cycles), 4);
        tick();

        clr();
        mem_reqM = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_wait($sformatf("to%0d", i));
            check("to_err0", 32'(mem_err), 0);
            tick();
        end
        #1;
        check("tor_sf", 32'(StallF), 0);
        check("tor_sm", 32'(StallM), 0);
        check("tor_fw", 32'(FlushW), 1);
        check("tor_err", 32'(mem_err), 0);
        mem_reqM = 0;
        tick();
        check("to_err", 32'(mem_err), 1);
        check("to_run", 32'(StallF), 0);
        check("to_fw", 32'(FlushW), 0);
        check("to_cnt", 32'(stall_cycles), 8);
        tick();
        check("to_err2", 32'(mem_err), 0);

        clr();
        mem_reqM = 1;
        #1;
        check("rw_sf", 32'(StallF), 1);
        tick();
        reset = 1;
        #1;
        check("rw_sf2", 32'(StallF), 0);
        check("rw_fd", 32'(FlushD), 1);
        check("rw_fe", 32'(FlushE), 1);
        check("rw_fw", 32'(FlushW), 1);
        tick();
        check("rw_cnt", 32'(stall_cycles), 0);
        check("rw_err", 32'(mem_err), 0);
        reset = 0;
        mem_reqM = 0;
        #1;
        check("rw_run", 32'(StallF), 0);
        check("rw_fw2", 32'(FlushW), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
